// File: rtl/bus_pkg.sv
// Shared definitions for the two-master/two-slave bus: response codes,
// slave responder states and master id constants.
package bus_pkg;

  // Response codes driven on the response bus
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] RESP_RETRY = 2'b10;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  // Master ids as carried by the grant
  localparam logic M1 = 1'b0;
  localparam logic M2 = 1'b1;

  // Slave responder states
  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_WAIT       = 4'd1,
    S_ACCESS     = 4'd2,
    S_ERR1       = 4'd3,
    S_ERR2       = 4'd4,
    S_SPL1       = 4'd5,
    S_SPL2       = 4'd6,
    S_SPLIT_HOLD = 4'd7,
    S_RTY1       = 4'd8,
    S_RTY2       = 4'd9
  } state_e;

endpackage

// File: rtl/slave_mem.sv
// Small register-file memory: synchronous write, combinational read,
// asynchronous clear. Out-of-range addresses never write and read as 0.
module slave_mem #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic              in_range;

  assign in_range = (int'(addr) < MEM_DEPTH);

  // Register array: cleared on reset, written on the clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (we && in_range) begin
      mem[addr] <= wdata;
    end
  end

  // Combinational read port
  always_comb begin
    rdata = '0;
    if (in_range) rdata = mem[addr];
  end

endmodule

// File: rtl/bus_slave_responder.sv
// Slave-side responder: decodes a selected transfer, inserts wait states,
// produces two-cycle ERROR/SPLIT/RETRY responses and tracks a pending split.
//
// Handshake: a request is taken when sel=1 is sampled while the FSM is in
// IDLE; addr/wdata/read_write are captured on that edge. The transfer is
// complete in the cycle where ready=1 is shown with its final response;
// ready=0 means the slave is still working and the master must hold off.
module bus_slave_responder
  import bus_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int MEM_DEPTH   = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              read_write,
  input  logic              master_id,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic [1:0]        response,
  output logic              split,
  output logic              split_mid,
  output logic              split_release,
  output logic [3:0]        state_dbg
);

  localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  state_e            state;
  logic [2:0]        wait_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_rw;

  logic              in_range;
  logic              go_access;
  logic              acc_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;

  assign state_dbg = state;
  assign in_range  = (int'(addr) < MEM_DEPTH);

  // The edge that enters ACCESS performs the write / captures read data.
  // With no wait states that edge is the accept edge itself, so the live
  // bus inputs are used instead of the latched copies.
  always_comb begin
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    acc_rw    = lat_rw;
    go_access = 1'b0;
    if (state == S_IDLE) begin
      mem_addr  = addr;
      mem_wdata = wdata;
      acc_rw    = read_write;
      go_access = sel && in_range && !busy && (WAIT_CYCLES == 0);
    end else if (state == S_WAIT) begin
      go_access = (wait_cnt == 3'd0);
    end
  end

  assign mem_we = go_access && acc_rw;

  slave_mem #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Responder FSM with registered outputs, wait counter and split tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      ready         <= 1'b1;
      response      <= RESP_OKAY;
      split         <= 1'b0;
      split_mid     <= M1;
      split_release <= 1'b0;
      rdata         <= '0;
      wait_cnt      <= 3'd0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      lat_rw        <= 1'b0;
    end else begin
      split_release <= 1'b0;
      case (state)
        S_IDLE: begin
          ready    <= 1'b1;
          response <= RESP_OKAY;
          if (sel) begin
            lat_addr  <= addr;
            lat_wdata <= wdata;
            lat_rw    <= read_write;
            if (!in_range) begin
              state    <= S_ERR1;
              ready    <= 1'b0;
              response <= RESP_ERROR;
            end else if (busy) begin
              state     <= S_SPL1;
              split_mid <= master_id;
              ready     <= 1'b0;
              response  <= RESP_SPLIT;
            end else if (WAIT_CYCLES > 0) begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_LOAD;
              ready    <= 1'b0;
            end else begin
              state <= S_ACCESS;
              if (!acc_rw) rdata <= mem_rdata;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 3'd0) begin
            state <= S_ACCESS;
            ready <= 1'b1;
            if (!acc_rw) rdata <= mem_rdata;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_ACCESS: begin
          state    <= S_IDLE;
          ready    <= 1'b1;
          response <= RESP_OKAY;
        end
        S_ERR1: begin
          state    <= S_ERR2;
          ready    <= 1'b1;
          response <= RESP_ERROR;
        end
        S_ERR2: begin
          state    <= S_IDLE;
          ready    <= 1'b1;
          response <= RESP_OKAY;
        end
        S_SPL1: begin
          state    <= S_SPL2;
          ready    <= 1'b1;
          response <= RESP_SPLIT;
        end
        S_SPL2: begin
          state    <= S_SPLIT_HOLD;
          ready    <= 1'b1;
          response <= RESP_OKAY;
          split    <= 1'b1;
        end
        S_SPLIT_HOLD: begin
          // Backend freeing up takes priority over a new request
          if (!busy) begin
            state         <= S_IDLE;
            split         <= 1'b0;
            split_release <= 1'b1;
            ready         <= 1'b1;
            response      <= RESP_OKAY;
          end else if (sel) begin
            state    <= S_RTY1;
            ready    <= 1'b0;
            response <= RESP_RETRY;
          end
        end
        S_RTY1: begin
          state    <= S_RTY2;
          ready    <= 1'b1;
          response <= RESP_RETRY;
        end
        S_RTY2: begin
          state    <= S_SPLIT_HOLD;
          ready    <= 1'b1;
          response <= RESP_OKAY;
        end
        default: begin
          state    <= S_IDLE;
          ready    <= 1'b1;
          response <= RESP_OKAY;
        end
      endcase
    end
  end

endmodule
